// File: rtl/pe_cluster_sequencer.sv
// Command sequencer for the 4-array PE cluster: clear/start, bounded wait, per-PE result drain.
// Optional SEQ_PERF_CNT_EN builds the start-to-done latency counter on perf_cycles.
module pe_cluster_sequencer #(
    parameter int NUM_LARGE_ARRAYS = 4,
    parameter int PE_ARRAY_ROWS    = 2,
    parameter int PE_ARRAY_COLS    = 2,
    parameter int SUBARRAY_ROWS    = 32,
    parameter int OUTPUT_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES   = 1024,
    localparam int NUM_PE = NUM_LARGE_ARRAYS * PE_ARRAY_ROWS * PE_ARRAY_COLS,
    localparam int VEC_W  = SUBARRAY_ROWS * OUTPUT_WIDTH,
    localparam int IDX_W  = $clog2(NUM_PE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [NUM_LARGE_ARRAYS-1:0] cmd_array_mask,
    input  logic [NUM_PE-1:0]           cmd_pe_mask,
    input  logic                        cmd_clear,
    output logic                        cluster_enable,
    output logic                        clear,
    output logic                        start,
    output logic [NUM_LARGE_ARRAYS-1:0] large_array_enable,
    output logic [NUM_PE-1:0]           pe_enable,
    input  logic                        cluster_busy,
    input  logic                        cluster_done,
    input  logic [NUM_PE*VEC_W-1:0]     output_vectors,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VEC_W-1:0]            out_data,
    output logic [IDX_W-1:0]            out_pe_idx,
    output logic                        out_last,
    output logic                        seq_done,
    output logic                        timeout_err,
    output logic [31:0]                 perf_cycles
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_WAIT, S_DRAIN} state_t;

    state_t                      state, state_nx;
    logic [NUM_LARGE_ARRAYS-1:0] arr_q;
    logic [NUM_PE-1:0]           eff_c, eff_q, pend_q;
    logic [CNT_W-1:0]            wait_cnt;
    logic [IDX_W-1:0]            cur_idx;
    logic                        cur_last, accept, handshake, wait_exit, wait_tmo;

    for (genvar a = 0; a < NUM_LARGE_ARRAYS; a++) begin : g_arr
        for (genvar r = 0; r < PE_ARRAY_ROWS; r++) begin : g_row
            for (genvar c = 0; c < PE_ARRAY_COLS; c++) begin : g_col
                localparam int IDX = (a * PE_ARRAY_ROWS + r) * PE_ARRAY_COLS + c;
                assign eff_c[IDX] = cmd_pe_mask[IDX] & cmd_array_mask[a];
            end
        end
    end

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign handshake = out_valid && out_ready;
    // First WAIT cycle (cnt==0) ignores done so a leftover done from the previous job can't end this one.
    assign wait_exit = (state == S_WAIT) && (wait_cnt != '0) && cluster_done && !cluster_busy;
    assign wait_tmo  = (state == S_WAIT) && !wait_exit && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Lowest pending PE is the current beat; pend_q clears one bit per handshake.
    always_comb begin
        cur_idx = '0;
        for (int i = NUM_PE - 1; i >= 0; i--)
            if (pend_q[i]) cur_idx = IDX_W'(i);
    end
    assign cur_last = ((pend_q & (pend_q - NUM_PE'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            arr_q       <= '0;
            eff_q       <= '0;
            pend_q      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            state    <= state_nx;
            seq_done <= 1'b0;
            if (accept) begin
                arr_q       <= cmd_array_mask;
                eff_q       <= eff_c;
                pend_q      <= eff_c;
                timeout_err <= 1'b0;
                seq_done    <= (eff_c == '0);
            end
            if (state == S_START)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_tmo) timeout_err <= 1'b1;
            if (handshake) begin
                pend_q[cur_idx] <= 1'b0;
                if (cur_last) seq_done <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx           = state;
        cluster_enable     = (state != S_IDLE);
        clear              = 1'b0;
        start              = 1'b0;
        large_array_enable = '0;
        pe_enable          = '0;
        out_valid          = 1'b0;
        out_data           = '0;
        out_pe_idx         = '0;
        out_last           = 1'b0;
        if (state != S_IDLE) begin
            large_array_enable = arr_q;
            pe_enable          = eff_q;
        end
        case (state)
            S_IDLE: begin
                if (accept && eff_c != '0) state_nx = cmd_clear ? S_CLEAR : S_START;
            end
            S_CLEAR: begin
                clear    = 1'b1;
                state_nx = S_START;
            end
            S_START: begin
                start    = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_exit)     state_nx = S_DRAIN;
                else if (wait_tmo) state_nx = S_IDLE;
            end
            S_DRAIN: begin
                out_valid  = 1'b1;
                out_pe_idx = cur_idx;
                out_last   = cur_last;
                out_data   = output_vectors[int'(cur_idx) * VEC_W +: VEC_W];
                if (handshake && cur_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_run, perf_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // perf_run counts the start cycle as 1; the exit cycle adds one more on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_run <= '0;
            perf_q   <= '0;
        end else begin
            if (state == S_START)     perf_run <= 32'd1;
            else if (state == S_WAIT) perf_run <= sat_inc(perf_run);
            if (wait_exit) perf_q <= sat_inc(perf_run);
        end
    end
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_cluster_sequencer.sv
// Directed bench for pe_cluster_sequencer: clear/start timing, masks, stalls, stale done, timeout, reset.
module tb_pe_cluster_sequencer;
    localparam int NA = 4, PR = 2, PC = 2, SR = 32, OW = 32, TO = 16;
    localparam int NUM_PE = NA * PR * PC;
    localparam int VEC_W  = SR * OW;
    localparam int IDX_W  = $clog2(NUM_PE);

    logic                    clk = 1'b0;
    logic                    rst, cmd_valid, cmd_ready, cmd_clear;
    logic [NA-1:0]           cmd_array_mask, large_array_enable;
    logic [NUM_PE-1:0]       cmd_pe_mask, pe_enable;
    logic                    cluster_enable, clear, start, cluster_busy, cluster_done;
    logic [NUM_PE*VEC_W-1:0] output_vectors;
    logic                    out_valid, out_ready, out_last, seq_done, timeout_err;
    logic [VEC_W-1:0]        out_data;
    logic [IDX_W-1:0]        out_pe_idx;
    logic [31:0]             perf_cycles;

    int n_vec = 0;
    int n_err = 0;

    pe_cluster_sequencer #(
        .NUM_LARGE_ARRAYS(NA), .PE_ARRAY_ROWS(PR), .PE_ARRAY_COLS(PC),
        .SUBARRAY_ROWS(SR), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_array_mask(cmd_array_mask), .cmd_pe_mask(cmd_pe_mask), .cmd_clear(cmd_clear),
        .cluster_enable(cluster_enable), .clear(clear), .start(start),
        .large_array_enable(large_array_enable), .pe_enable(pe_enable),
        .cluster_busy(cluster_busy), .cluster_done(cluster_done),
        .output_vectors(output_vectors),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pe_idx(out_pe_idx), .out_last(out_last),
        .seq_done(seq_done), .timeout_err(timeout_err), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] vec(input int p);
        logic [VEC_W-1:0] v;
        for (int e = 0; e < SR; e++) v[e*OW +: OW] = {8'(p), 8'(e), 16'hC3A5};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input logic [31:0] exp);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, exp);
`else
        chk("perf_cycles_off", perf_cycles, 32'd0);
`endif
    endtask

    // Issue a command; returns in the start-pulse cycle.
    task automatic go(input logic [3:0] am, input logic [15:0] pm, input bit clr,
                      input logic [15:0] exp_eff);
        cmd_valid = 1'b1; cmd_array_mask = am; cmd_pe_mask = pm; cmd_clear = clr;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("pe_enable", pe_enable, exp_eff);
        chk("array_enable", large_array_enable, am);
        if (clr) begin
            chk("clear_pulse", clear, 1);
            chk("start_early", start, 0);
            tick;
        end
        chk("clear_off", clear, 0);
        chk("start_pulse", start, 1);
        chk("cluster_enable", cluster_enable, 1);
    endtask

    task automatic beat(input int i, input bit last);
        logic [VEC_W-1:0] ev;
        ev = vec(i);
        chk("out_valid", out_valid, 1);
        chk("out_pe_idx", out_pe_idx, i);
        chk("out_last", out_last, last);
        chk("data_lo", out_data[63:0], ev[63:0]);
        chk("data_hi", out_data[VEC_W-1 -: 64], ev[VEC_W-1 -: 64]);
        chk("seq_done_drain", seq_done, 0);
    endtask

    // Drains every set bit of eff; with stall, beat 1 sees out_ready low for two cycles.
    task automatic drain(input logic [15:0] eff, input bit stall);
        int b;
        bit last;
        b = 0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (eff[i]) begin
                last = ((eff >> (i + 1)) == 16'd0);
                if (stall && b == 1) begin
                    out_ready = 1'b0;
                    repeat (2) begin
                        beat(i, last);
                        tick;
                    end
                    out_ready = 1'b1;
                end
                beat(i, last);
                tick;
                b++;
            end
        end
        chk("seq_done_end", seq_done, 1);
        chk("out_valid_end", out_valid, 0);
        chk("cmd_ready_end", cmd_ready, 1);
        chk("pe_enable_idle", pe_enable, 0);
        tick;
        chk("seq_done_once", seq_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_array_mask = '0; cmd_pe_mask = '0;
        cluster_busy = 1'b0; cluster_done = 1'b0; out_ready = 1'b1;
        for (int p = 0; p < NUM_PE; p++) output_vectors[p*VEC_W +: VEC_W] = vec(p);
        repeat (3) tick;

        // reset state
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_enable", cluster_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_pe_enable", pe_enable, 0);
        chk("rst_perf", perf_cycles, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // full mask with clear, done 10 cycles after start
        go(4'hF, 16'hFFFF, 1, 16'hFFFF);
        cluster_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk("wait_no_valid", out_valid, 0);
            chk("wait_no_start", start, 0);
            if (k == 10) begin cluster_done = 1'b1; cluster_busy = 1'b0; end
        end
        tick;
        cluster_done = 1'b0;
        drain(16'hFFFF, 0);
        chk_perf(32'd11);

        // only array 2 enabled
        go(4'b0100, 16'hFFFF, 0, 16'h0F00);
        tick; tick;
        cluster_done = 1'b1;
        tick;
        cluster_done = 1'b0;
        drain(16'h0F00, 0);
        chk_perf(32'd3);

        // drain with out_ready 1-0-0-1
        go(4'hF, 16'h00F0, 0, 16'h00F0);
        tick; tick;
        cluster_done = 1'b1;
        tick;
        cluster_done = 1'b0;
        drain(16'h00F0, 1);

        // done held from before start, busy for 5 cycles after start
        cluster_done = 1'b1; cluster_busy = 1'b1;
        go(4'b0001, 16'h0003, 0, 16'h0003);
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk("busy_no_exit", out_valid, 0);
            if (k == 6) cluster_busy = 1'b0;
        end
        tick;
        cluster_done = 1'b0;
        drain(16'h0003, 0);
        chk_perf(32'd7);

        // stale done with busy low: first WAIT cycle must not exit
        cluster_done = 1'b1;
        go(4'hF, 16'h0001, 0, 16'h0001);
        tick;
        chk("stale_guard", out_valid, 0);
        tick;
        chk("second_wait", out_valid, 0);
        tick;
        cluster_done = 1'b0;
        drain(16'h0001, 0);
        chk_perf(32'd3);

        // timeout after TO wait cycles
        go(4'hF, 16'hFFFF, 0, 16'hFFFF);
        for (int k = 1; k <= TO; k++) begin
            tick;
            chk("tmo_pending", timeout_err, 0);
            chk("tmo_in_wait", cluster_enable, 1);
        end
        tick;
        chk("tmo_set", timeout_err, 1);
        chk("tmo_idle", cluster_enable, 0);
        chk("tmo_no_valid", out_valid, 0);
        chk("tmo_no_done", seq_done, 0);
        chk("tmo_ready", cmd_ready, 1);
        tick;
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_no_done2", seq_done, 0);
        chk_perf(32'd3);

        // empty effective mask clears timeout and completes without start
        cmd_valid = 1'b1; cmd_array_mask = 4'b0001; cmd_pe_mask = 16'hFFF0; cmd_clear = 1'b1;
        tick;
        cmd_valid = 1'b0;
        chk("empty_done", seq_done, 1);
        chk("empty_tmo_clr", timeout_err, 0);
        chk("empty_no_clear", clear, 0);
        chk("empty_no_start", start, 0);
        chk("empty_idle", cluster_enable, 0);
        tick;
        chk("empty_done_pulse", seq_done, 0);
        chk("empty_no_start2", start, 0);

        // reset mid-drain after 3 beats
        go(4'hF, 16'hFFFF, 0, 16'hFFFF);
        tick; tick;
        cluster_done = 1'b1;
        tick;
        cluster_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(i, 0);
            tick;
        end
        chk("pre_rst_idx", out_pe_idx, 3);
        rst = 1'b1;
        tick;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_enable", cluster_enable, 0);
        chk("mrst_clear", clear, 0);
        chk("mrst_start", start, 0);
        chk("mrst_pe_en", pe_enable, 0);
        chk("mrst_arr_en", large_array_enable, 0);
        chk("mrst_done", seq_done, 0);
        rst = 1'b0;
        #1;
        chk("mrst_ready", cmd_ready, 1);
        chk("mrst_perf", perf_cycles, 0);
        tick;
        chk("mrst_no_done", seq_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
